accelerator_data_feeder: RTL and testbench



---
 rtl/accelerator_data_feeder.sv | 143 ++++++++++++++
 tb/tb_accelerator_data_feeder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/accelerator_data_feeder.sv
// Operand buffer for one accelerator job: loads TOTAL_WORDS words from a valid/ready
// stream, then serves them in load order, one registered word per read request.
module accelerator_data_feeder #(
   parameter int DATA_WIDTH  = 16,
   parameter int TOTAL_WORDS = 128,
   parameter int PTR_WIDTH   = $clog2(TOTAL_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid_i,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  s_ready_o,
   output logic                  data_rdy_o,
   input  logic                  read_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  done_o,
   input  logic                  job_clr_i,
   output logic                  rd_err_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_SERVE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(TOTAL_WORDS - 1);
   localparam logic [PTR_WIDTH-1:0] PTR_ZERO = PTR_WIDTH'(0);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

   state_t                state_r, state_next_s;
   logic [PTR_WIDTH-1:0]  wr_ptr_r, wr_ptr_next_s;
   logic [PTR_WIDTH-1:0]  rd_ptr_r, rd_ptr_next_s;
   logic                  rd_err_r, rd_err_next_s;
   logic                  rd_valid_r;
   logic [DATA_WIDTH-1:0] rd_data_r;
   logic                  s_ready_r, data_rdy_r, done_r;
   logic                  mem_we_s, rd_fire_s;
   logic [DATA_WIDTH-1:0] mem_r [TOTAL_WORDS];

   // Next-state, pointer and error-flag logic; s_ready_r doubles as the LOAD indicator.
   always_comb begin
      state_next_s  = state_r;
      wr_ptr_next_s = wr_ptr_r;
      rd_ptr_next_s = rd_ptr_r;
      rd_err_next_s = rd_err_r;
      mem_we_s      = 1'b0;
      rd_fire_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_next_s = ST_LOAD;
            if (read_en_i) rd_err_next_s = 1'b1;
            else           rd_err_next_s = rd_err_r;
         end
         ST_LOAD: begin
            if (s_valid_i && s_ready_r) begin
               mem_we_s = 1'b1;
               if (wr_ptr_r == LAST_IDX) begin
                  wr_ptr_next_s = PTR_ZERO;
                  state_next_s  = ST_READY;
               end else begin
                  wr_ptr_next_s = wr_ptr_r + PTR_ONE;
               end
            end else begin
               mem_we_s = 1'b0;
            end
            if (read_en_i) rd_err_next_s = 1'b1;
            else           rd_err_next_s = rd_err_r;
         end
         ST_READY, ST_SERVE: begin
            if (read_en_i) begin
               rd_fire_s = 1'b1;
               if (rd_ptr_r == LAST_IDX) begin
                  rd_ptr_next_s = PTR_ZERO;
                  state_next_s  = ST_DONE;
               end else begin
                  rd_ptr_next_s = rd_ptr_r + PTR_ONE;
                  state_next_s  = ST_SERVE;
               end
            end else begin
               rd_fire_s = 1'b0;
            end
         end
         ST_DONE: begin
            // A clear on the same cycle as a stray read wins and leaves the flag cleared.
            if (job_clr_i) begin
               state_next_s  = ST_LOAD;
               wr_ptr_next_s = PTR_ZERO;
               rd_ptr_next_s = PTR_ZERO;
               rd_err_next_s = 1'b0;
            end else if (read_en_i) begin
               rd_err_next_s = 1'b1;
            end else begin
               rd_err_next_s = rd_err_r;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, pointers and registered outputs; status flags are decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         rd_err_r   <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= {DATA_WIDTH{1'b0}};
         s_ready_r  <= 1'b0;
         data_rdy_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         wr_ptr_r   <= wr_ptr_next_s;
         rd_ptr_r   <= rd_ptr_next_s;
         rd_err_r   <= rd_err_next_s;
         rd_valid_r <= rd_fire_s;
         if (rd_fire_s) rd_data_r <= mem_r[rd_ptr_r];
         s_ready_r  <= (state_next_s == ST_LOAD);
         data_rdy_r <= (state_next_s == ST_READY);
         done_r     <= (state_next_s == ST_DONE);
      end
   end

   // Operand storage, deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) mem_r[wr_ptr_r] <= s_data_i;
   end

   assign s_ready_o  = s_ready_r;
   assign data_rdy_o = data_rdy_r;
   assign done_o     = done_r;
   assign rd_valid_o = rd_valid_r;
   assign rd_data_o  = rd_data_r;
   assign rd_err_o   = rd_err_r;

endmodule

// File: tb/tb_accelerator_data_feeder.sv
// Self-checking bench for accelerator_data_feeder: random stimulus against a
// queue-based model of one job (words loaded, words served, sticky error).
module tb_accelerator_data_feeder;

   localparam int DW = 16;
   localparam int T  = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          data_rdy;
   logic          read_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          done;
   logic          job_clr;
   logic          rd_err;

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   logic [DW-1:0] buf_q[$];
   int            served;
   bit            boot;
   bit            m_err;
   logic [DW-1:0] m_data;

   accelerator_data_feeder #(.DATA_WIDTH(DW), .TOTAL_WORDS(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
      .data_rdy_o(data_rdy),
      .read_en_i(read_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
      .done_o(done), .job_clr_i(job_clr), .rd_err_o(rd_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      buf_q.delete();
      served = 0;
      boot   = 1'b1;
      m_err  = 1'b0;
      m_data = '0;
   endtask

   // Drive one cycle of inputs (called at a falling edge), advance the model, check after the edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic re, input logic clr);
      bit exp_valid;
      s_valid = v; s_data = d; read_en = re; job_clr = clr;
      exp_valid = 1'b0;
      if (boot) begin
         boot = 1'b0;
         if (re) m_err = 1'b1;
      end else if (buf_q.size() < T) begin
         if (v) buf_q.push_back(d);
         if (re) m_err = 1'b1;
      end else if (served < T) begin
         if (re) begin
            exp_valid = 1'b1;
            m_data    = buf_q[served];
            served++;
         end
      end else begin
         if (clr) begin
            buf_q.delete();
            served = 0;
            m_err  = 1'b0;
         end else if (re) begin
            m_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check_eq("s_ready",  {31'd0, s_ready},  {31'd0, (buf_q.size() < T)});
      check_eq("data_rdy", {31'd0, data_rdy}, {31'd0, (buf_q.size() == T && served == 0)});
      check_eq("done",     {31'd0, done},     {31'd0, (buf_q.size() == T && served == T)});
      check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
      check_eq("rd_data",  {16'd0, rd_data},  {16'd0, m_data});
      check_eq("rd_err",   {31'd0, rd_err},   {31'd0, m_err});
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_outs"}, {26'd0, s_ready, data_rdy, rd_valid, done, rd_err, 1'b0}, 32'd0);
      check_eq({tag, "_data"}, {16'd0, rd_data}, 32'd0);
   endtask

   // Load a full job starting at base; three idle gaps are sprinkled at random positions.
   task automatic load_job(input logic [DW-1:0] base);
      int g0, g1, g2, idx;
      g0 = $urandom_range(0, T - 1);
      g1 = $urandom_range(0, T - 1);
      g2 = $urandom_range(0, T - 1);
      idx = 0;
      while (idx < T) begin
         if (idx == g0 || idx == g1 || idx == g2) begin
            step(1'b0, DW'($urandom), 1'b0, 1'b0);
            if (idx == g0) g0 = -1;
            else if (idx == g1) g1 = -1;
            else g2 = -1;
         end else begin
            step(1'b1, base + DW'(idx), 1'b0, 1'b0);
            idx++;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; read_en = 1'b0; job_clr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // IDLE cycle with s_valid already high: first word lands on the 2nd edge
      step(1'b1, 16'h0000, 1'b0, 1'b0);
      check_eq("first_idle_loaded", buf_q.size(), 32'd0);
      for (int i = 0; i < T; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      step(1'b1, 16'hDEAD, 1'b0, 1'b0);

      // first-layer pattern then back-to-back
      for (int i = 0; i < 32; i++) step(1'b0, 16'h0, (i % 2 == 0), 1'b0);
      for (int i = 0; i < T - 16; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b1);

      // second job with gapped load; first read must return 0x1000
      load_job(16'h1000);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check_eq("job2_first", {16'd0, rd_data}, 32'h1000);
      for (int k = 0; k < 1000 && served < 40; k++)
         step(1'b0, 16'h0, 1'($urandom_range(0, 1)), 1'b0);
      check_eq("serve_bound", served, 32'd40);

      // asynchronous reset mid-SERVE
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // random job: random valid/data, stray reads during load set the sticky error
      step(1'b0, 16'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2000 && buf_q.size() < T; k++)
         step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 15) == 0), 1'b0);
      check_eq("load_bound", buf_q.size(), T);
      for (int k = 0; k < 2000 && served < T; k++)
         step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
      check_eq("read_bound", served, T);
      for (int k = 0; k < 8; k++)
         step(1'b0, 16'h0, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      load_job(DW'($urandom));
      for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
